// File: rtl/lut_square_module.sv
// ---------------------------------------------------------------------------
// lut_square_module
//
// Back end of the pipelined quarter-square multiplier. The pre-add stage
// supplies i1 = a+b and i2 = a-b as 9-bit two's complement values. This block
// forms a*b as floor(i1^2/4) - floor(i2^2/4). The result is exact because i1
// and i2 always have the same parity, so their fractional parts cancel.
//
// Pipeline (one register level per stage):
//   stage 1 : r_m1/r_m2   = |i1|, |i2|                 (9-bit unsigned, 0..256)
//   stage 2 : r_q1/r_q2   = floor(m^2/4)               (15-bit unsigned, 0..16384)
//   stage 3 : r_prod      = {1'b0,q1} - {1'b0,q2}      (16-bit signed)
//
// Handshake: the whole pipe stalls only while the output holds a valid
// product that the consumer does not take. Bubbles move forward like data,
// so an empty stage never blocks the stages upstream of it.
//
// Configuration macro: SQ_LUT_ROM_EN
//   defined   : stage 2 looks up the squares in two 257x15 ROMs (one per
//               operand). The stage 2 register acts as the registered read
//               port.
//   undefined : stage 2 squares arithmetically and keeps bits [16:2].
//   Both builds give the same latency, handshake and bit-exact results.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   i1         in   9   a+b, signed, -256..254
//   i2         in   9   a-b, signed, -255..255
//   in_valid   in   1   i1/i2 carry a valid pair this cycle
//   in_ready   out  1   pipe can accept a pair this cycle
//   product    out  16  signed a*b, -16256..16384
//   out_valid  out  1   product is valid
//   out_ready  in   1   consumer takes product this cycle
// ---------------------------------------------------------------------------
module lut_square_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  i1,
  input  logic [8:0]  i2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] product,
  output logic        out_valid,
  input  logic        out_ready
);

  // Pipeline control
  logic        w_stall;
  logic        w_advance;

  // Stage valid bits
  logic        r_v1;
  logic        r_v2;
  logic        r_v3;

  // Stage 1: magnitudes
  logic [8:0]  w_abs1;
  logic [8:0]  w_abs2;
  logic [8:0]  r_m1;
  logic [8:0]  r_m2;

  // Stage 2: quarter squares
  logic [14:0] w_q1;
  logic [14:0] w_q2;
  logic [14:0] r_q1;
  logic [14:0] r_q2;

  // Stage 3: difference
  logic [15:0] r_prod;

  // Nine-bit negation of a negative value. -256 (9'h100) negates back to
  // 9'h100, which read as unsigned is 256, the magnitude we need.
  function automatic logic [8:0] absVal(input logic [8:0] x);
    return x[8] ? (~x + 9'd1) : x;
  endfunction

  // A full output that is not being taken freezes every stage at once.
  // Holding all stages is simpler than per-stage bubble collapsing and keeps
  // in_ready a single gate away from out_ready.
  assign w_stall   = r_v3 && !out_ready;
  assign w_advance = !w_stall;
  assign in_ready  = w_advance;

  assign w_abs1 = absVal(i1);
  assign w_abs2 = absVal(i2);

`ifdef SQ_LUT_ROM_EN
  // Quarter-square tables, entry k = floor(k^2/4). Two identical copies let
  // both operands be looked up in the same cycle from single-port ROMs.
  logic [14:0] r_romA [0:256];
  logic [14:0] r_romB [0:256];

  initial begin
    for (int k = 0; k < 257; k++) begin
      r_romA[k] = 15'((k * k) / 4);
      r_romB[k] = 15'((k * k) / 4);
    end
  end

  assign w_q1 = r_romA[r_m1];
  assign w_q2 = r_romB[r_m2];
`else
  // 256^2 = 65536 needs 17 bits; the two LSBs are the floor-by-4 that the
  // same-parity argument lets us drop without losing exactness.
  assign w_q1 = 15'(({8'd0, r_m1} * {8'd0, r_m1}) >> 2);
  assign w_q2 = 15'(({8'd0, r_m2} * {8'd0, r_m2}) >> 2);
`endif

  // Valid bits follow their upstream neighbour whenever the pipe moves, so a
  // bubble simply travels down the pipe like any other entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Stage 1 data only loads for a real pair, so a bubble leaves the last
  // magnitudes in place instead of toggling the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1 <= 9'd0;
      r_m2 <= 9'd0;
    end else if (w_advance && in_valid) begin
      r_m1 <= w_abs1;
      r_m2 <= w_abs2;
    end
  end

  // Stage 2 register: captures either the ROM lookup or the arithmetic
  // square, depending on the build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= 15'd0;
      r_q2 <= 15'd0;
    end else if (w_advance && r_v1) begin
      r_q1 <= w_q1;
      r_q2 <= w_q2;
    end
  end

  // Stage 3 register: both quarter squares are at most 16384, so their
  // zero-extended difference always fits in 16-bit two's complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= 16'd0;
    end else if (w_advance && r_v2) begin
      r_prod <= {1'b0, r_q1} - {1'b0, r_q2};
    end
  end

  assign product   = r_prod;
  assign out_valid = r_v3;

endmodule

// File: tb/tb_lut_square_module.sv
// ---------------------------------------------------------------------------
// tb_lut_square_module
//
// Directed bench for lut_square_module: reset state, single-pair latency,
// operand extremes, random streaming, full 256x256 sweep, output
// backpressure and reset while pairs are in flight. Expected products come
// from a*b computed here and held in an in-order queue.
// ---------------------------------------------------------------------------
module tb_lut_square_module;

  logic        clk;
  logic        rst_n;
  logic [8:0]  i1;
  logic [8:0]  i2;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;

  int          checkCount;
  int          passCount;
  int          failCount;
  int          outCount;
  int          gapCount;
  int          idx;
  logic        acc;
  logic        lastOutXfer;
  logic        stallPrev;
  logic [15:0] heldProduct;
  logic [15:0] expQ [$];

  lut_square_module dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i1        (i1),
    .i2        (i2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, counts a pass, or reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one pair as the pre-add stage would: i1 = a+b, i2 = a-b in 9 bits.
  task automatic applyStimulus(input logic valid, input logic [7:0] a,
                               input logic [7:0] b);
    in_valid = valid;
    i1 = {a[7], a} + {b[7], b};
    i2 = {a[7], a} - {b[7], b};
  endtask

  // One clock cycle of streaming: drive, sample mid-cycle, score the output,
  // record an accepted input, then move to just after the next rising edge.
  task automatic runCycle(input logic valid, input logic [7:0] a,
                          input logic [7:0] b, input logic rdy,
                          output logic accepted);
    logic [15:0] expected;
    applyStimulus(valid, a, b);
    out_ready = rdy;
    #2;
    lastOutXfer = out_valid && out_ready;
    if (!rdy && out_valid) begin
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      if (stallPrev) checkOutput("stall_hold", 32'(product), 32'(heldProduct));
      heldProduct = product;
      stallPrev = 1'b1;
    end else begin
      stallPrev = 1'b0;
    end
    if (lastOutXfer) begin
      outCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 32'(expQ.size()), 32'd1);
      end else begin
        expected = expQ.pop_front();
        checkOutput("stream_product", 32'(product), 32'(expected));
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) expQ.push_back(16'(int'($signed(a)) * int'($signed(b))));
    @(posedge clk);
    #1;
  endtask

  // Idle cycles until every expected product has come out (bounded).
  task automatic drain(input string tag);
    for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
      runCycle(1'b0, 8'h00, 8'h00, 1'b1, acc);
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  // a=5, b=3: presented in one cycle, valid after the third edge, then gone.
  task automatic basicLatency(input string tag);
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h05, 8'h03);
    #2;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput({tag, "_e1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_e2_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_e3_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_e3_product"}, 32'(product), 32'd15);
    @(posedge clk); #1;
    checkOutput({tag, "_e4_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    failCount   = 0;
    outCount    = 0;
    gapCount    = 0;
    idx         = 0;
    acc         = 1'b0;
    lastOutXfer = 1'b0;
    stallPrev   = 1'b0;
    heldProduct = 16'd0;
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00);

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic latency");
    basicLatency("basic");

    $display("[TB] extremes");
    applyStimulus(1'b1, 8'h80, 8'h80);
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h7F, 8'h80);
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h00, 8'h00);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("ext_neg128sq_valid", 32'(out_valid), 32'd1);
    checkOutput("ext_neg128sq", 32'(product), 32'h4000);
    @(posedge clk); #1;
    checkOutput("ext_min_valid", 32'(out_valid), 32'd1);
    checkOutput("ext_min", 32'(product), 32'hC080);
    @(posedge clk); #1;
    checkOutput("ext_zero_valid", 32'(out_valid), 32'd1);
    checkOutput("ext_zero", 32'(product), 32'h0000);
    @(posedge clk); #1;
    checkOutput("ext_after_valid", 32'(out_valid), 32'd0);

    $display("[TB] random stream");
    outCount = 0;
    gapCount = 0;
    for (int n = 0; n < 256; n++) begin
      runCycle(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'b1, acc);
      if (n >= 3 && !lastOutXfer) gapCount++;
    end
    drain("random_drain");
    checkOutput("random_count", 32'(outCount), 32'd256);
    checkOutput("random_gaps", 32'(gapCount), 32'd0);

    $display("[TB] exhaustive sweep");
    outCount = 0;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        runCycle(1'b1, 8'(x), 8'(y), 1'b1, acc);
      end
    end
    drain("sweep_drain");
    checkOutput("sweep_count", 32'(outCount), 32'd65536);

    $display("[TB] backpressure");
    outCount = 0;
    idx = 0;
    for (int c = 0; c < 100 && idx < 20; c++) begin
      runCycle(1'b1, 8'(idx * 13 + 1), 8'(200 - idx * 11),
               !(c >= 8 && c < 13), acc);
      if (acc) idx++;
    end
    checkOutput("bp_accepted", 32'(idx), 32'd20);
    drain("bp_drain");
    checkOutput("bp_count", 32'(outCount), 32'd20);

    $display("[TB] reset in flight");
    runCycle(1'b1, 8'h05, 8'h03, 1'b1, acc);
    runCycle(1'b1, 8'h0A, 8'hF6, 1'b1, acc);
    runCycle(1'b1, 8'h7F, 8'h7F, 1'b1, acc);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_product", 32'(product), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      runCycle(1'b0, 8'h00, 8'h00, 1'b1, acc);
      checkOutput("no_stale_valid", 32'(out_valid), 32'd0);
    end
    basicLatency("post_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
